// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter assembler: FSM state codes,
// ASCII codes for space/unknown and the dot/dash symbol encoding.
package morse_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_COLLECT    = 2'd0;
    localparam logic [1:0] ST_LOOKUP     = 2'd1;
    localparam logic [1:0] ST_PUSH_CHAR  = 2'd2;
    localparam logic [1:0] ST_PUSH_SPACE = 2'd3;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    // First received symbol lands in bit 0 of the pattern.
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int SYM_W   = 5;
    localparam int CNT_W   = 3;
    localparam int SYM_MAX = 5;

endpackage

// File: rtl/morse_letter_assembler_if.sv
// Symbol-event inputs and character-stream output of the Morse letter assembler.
// master = producer of symbol events / consumer of characters, slave = assembler.
interface morse_letter_assembler_if;
    logic       dot;
    logic       dash;
    logic       lg;
    logic       wg;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       overflow;

    modport master (
        output dot, dash, lg, wg, char_ready,
        input  char_data, char_valid, overflow
    );

    modport slave (
        input  dot, dash, lg, wg, char_ready,
        output char_data, char_valid, overflow
    );
endinterface

// File: rtl/morse_ascii_lut.sv
// Combinational Morse pattern to ASCII table: letters A-Z and digits 0-9,
// anything else (or a pattern flagged bad) maps to '?'.
module morse_ascii_lut
    import morse_pkg::*;
(
    input  logic [SYM_W-1:0] i_sym,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_bad,
    output logic [7:0]       o_code
);
    // Key is {count, pattern}; pattern bit 0 is the first symbol, 1 = dash.
    always_comb begin
        o_code = ASCII_UNKNOWN;
        if (!i_bad) begin
            case ({i_cnt, i_sym})
                {3'd2, 5'd2}:  o_code = "A";
                {3'd4, 5'd1}:  o_code = "B";
                {3'd4, 5'd5}:  o_code = "C";
                {3'd3, 5'd1}:  o_code = "D";
                {3'd1, 5'd0}:  o_code = "E";
                {3'd4, 5'd4}:  o_code = "F";
                {3'd3, 5'd3}:  o_code = "G";
                {3'd4, 5'd0}:  o_code = "H";
                {3'd2, 5'd0}:  o_code = "I";
                {3'd4, 5'd14}: o_code = "J";
                {3'd3, 5'd5}:  o_code = "K";
                {3'd4, 5'd2}:  o_code = "L";
                {3'd2, 5'd3}:  o_code = "M";
                {3'd2, 5'd1}:  o_code = "N";
                {3'd3, 5'd7}:  o_code = "O";
                {3'd4, 5'd6}:  o_code = "P";
                {3'd4, 5'd11}: o_code = "Q";
                {3'd3, 5'd2}:  o_code = "R";
                {3'd3, 5'd0}:  o_code = "S";
                {3'd1, 5'd1}:  o_code = "T";
                {3'd3, 5'd4}:  o_code = "U";
                {3'd4, 5'd8}:  o_code = "V";
                {3'd3, 5'd6}:  o_code = "W";
                {3'd4, 5'd9}:  o_code = "X";
                {3'd4, 5'd13}: o_code = "Y";
                {3'd4, 5'd3}:  o_code = "Z";
                {3'd5, 5'd31}: o_code = "0";
                {3'd5, 5'd30}: o_code = "1";
                {3'd5, 5'd28}: o_code = "2";
                {3'd5, 5'd24}: o_code = "3";
                {3'd5, 5'd16}: o_code = "4";
                {3'd5, 5'd0}:  o_code = "5";
                {3'd5, 5'd1}:  o_code = "6";
                {3'd5, 5'd3}:  o_code = "7";
                {3'd5, 5'd7}:  o_code = "8";
                {3'd5, 5'd15}: o_code = "9";
                default:       o_code = ASCII_UNKNOWN;
            endcase
        end
    end
endmodule

// File: rtl/morse_letter_assembler.sv
// Assembles dot/dash events into ASCII letters and word spaces, queued in a small FIFO.
// Define MORSE_TIMEOUT_EN to flush a pending letter after TIMEOUT_CYCLES idle cycles.
module morse_letter_assembler
    import morse_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 35_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    morse_letter_assembler_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t           r_state, w_state_next;
    logic [SYM_W-1:0] r_sym, w_sym_next, w_base_sym;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_base_cnt;
    logic             r_bad, w_bad_next, w_base_bad;
    logic             r_wg_pend, w_wg_pend_next;
    logic [7:0]       r_code, w_lut_code, w_push_data;
    logic             w_push;
    logic             r_any_written, r_last_space;
    logic             w_sym_ev, w_sym_wr, w_timeout, w_lg_ev;

    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic             w_empty, w_full, w_pop, w_wr_ok;
    logic             r_overflow;

    assign w_sym_ev = bus.dot ^ bus.dash;

    // Leaving LOOKUP the code is already captured, so symbols arriving from then on
    // build on a cleared pattern instead of being lost.
    assign w_base_sym = (r_state == ST_LOOKUP) ? '0 : r_sym;
    assign w_base_cnt = (r_state == ST_LOOKUP) ? '0 : r_cnt;
    assign w_base_bad = (r_state == ST_LOOKUP) ? 1'b0 : r_bad;

    assign w_sym_wr   = w_sym_ev && (w_base_cnt < CNT_W'(SYM_MAX));
    assign w_cnt_next = w_sym_wr ? (w_base_cnt + CNT_W'(1)) : w_base_cnt;
    assign w_bad_next = w_base_bad | (w_sym_ev && !w_sym_wr);

    genvar gi;
    generate
        for (gi = 0; gi < SYM_W; gi++) begin : g_sym_bit
            assign w_sym_next[gi] = (w_sym_wr && (w_base_cnt == CNT_W'(gi)))
                                    ? (bus.dash ? SYM_DASH : SYM_DOT)
                                    : w_base_sym[gi];
        end
    endgenerate

`ifdef MORSE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] r_idle;
    logic              w_idle;

    assign w_idle    = (r_state == ST_COLLECT) && (r_cnt != '0) &&
                       !(bus.dot || bus.dash || bus.lg || bus.wg);
    assign w_timeout = w_idle && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_idle <= '0;
        else if (!w_idle || w_timeout)
            r_idle <= '0;
        else
            r_idle <= r_idle + IDLE_W'(1);
    end
`else
    // No idle flush in this build; the parameter stays part of the interface.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    assign w_lg_ev = bus.lg || w_timeout;

    morse_ascii_lut u_lut (
        .i_sym  (r_sym),
        .i_cnt  (r_cnt),
        .i_bad  (r_bad),
        .o_code (w_lut_code)
    );

    always_comb begin
        w_state_next   = r_state;
        w_wg_pend_next = r_wg_pend;
        w_push         = 1'b0;
        w_push_data    = r_code;
        case (r_state)
            ST_COLLECT: begin
                if (bus.wg) begin
                    if (r_cnt != '0) begin
                        w_state_next   = ST_LOOKUP;
                        w_wg_pend_next = 1'b1;
                    end else begin
                        w_state_next   = ST_PUSH_SPACE;
                    end
                end else if (w_lg_ev && (r_cnt != '0)) begin
                    w_state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: w_state_next = ST_PUSH_CHAR;
            ST_PUSH_CHAR: begin
                w_push         = 1'b1;
                w_wg_pend_next = 1'b0;
                w_state_next   = r_wg_pend ? ST_PUSH_SPACE : ST_COLLECT;
            end
            ST_PUSH_SPACE: begin
                w_push       = r_any_written && !r_last_space;
                w_push_data  = ASCII_SPACE;
                w_state_next = ST_COLLECT;
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_COLLECT;
            r_sym         <= '0;
            r_cnt         <= '0;
            r_bad         <= 1'b0;
            r_wg_pend     <= 1'b0;
            r_code        <= 8'h00;
            r_any_written <= 1'b0;
            r_last_space  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sym     <= w_sym_next;
            r_cnt     <= w_cnt_next;
            r_bad     <= w_bad_next;
            r_wg_pend <= w_wg_pend_next;
            if (r_state == ST_LOOKUP)
                r_code <= w_lut_code;
            if (w_push) begin
                r_any_written <= 1'b1;
                r_last_space  <= (w_push_data == ASCII_SPACE);
            end
        end
    end

    // FIFO with one extra pointer bit to tell full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && bus.char_ready;
    assign w_wr_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_push && !w_wr_ok)
                r_overflow <= 1'b1;
        end
    end

    assign bus.char_valid = !w_empty;
    assign bus.char_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_morse_letter_assembler.sv
// Directed plus randomized bench for morse_letter_assembler against a table-driven
// model of Morse decoding, word-space suppression and FIFO behaviour.
module tb_morse_letter_assembler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morse_letter_assembler_if bus_if ();

    morse_letter_assembler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    bit m_any;
    bit m_last_space;

    string ALPHA = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    string MORSE [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                          "--...", "---..", "----."};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_decode(input string p);
        if (p.len() == 0 || p.len() > 5) return 8'h3F;
        for (int i = 0; i < 36; i++)
            if (MORSE[i] == p) return ALPHA[i];
        return 8'h3F;
    endfunction

    task automatic m_write(input logic [7:0] c);
        exp_q.push_back(c);
        m_any        = 1'b1;
        m_last_space = (c == 8'h20);
    endtask

    task automatic m_letter(input string p);
        m_write(model_decode(p));
    endtask

    task automatic m_gap();
        if (m_any && !m_last_space) m_write(8'h20);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_sym(input bit is_dash);
        bus_if.dot  = !is_dash;
        bus_if.dash = is_dash;
        tick();
        bus_if.dot  = 1'b0;
        bus_if.dash = 1'b0;
    endtask

    task automatic send_lg();
        bus_if.lg = 1'b1;
        tick();
        bus_if.lg = 1'b0;
    endtask

    task automatic send_wg();
        bus_if.wg = 1'b1;
        tick();
        bus_if.wg = 1'b0;
    endtask

    task automatic send_pat(input string p);
        for (int i = 0; i < p.len(); i++) begin
            send_sym(p[i] == "-");
            wait_ticks($urandom_range(0, 2));
        end
    endtask

    task automatic drain();
        int budget;
        budget = 32;
        bus_if.char_ready = 1'b1;
        while (bus_if.char_valid === 1'b1 && budget > 0) begin
            obs_q.push_back(bus_if.char_data);
            tick();
            budget--;
        end
        bus_if.char_ready = 1'b0;
        check("drain_empty", {31'd0, bus_if.char_valid}, 32'd0);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            $display("%s char %0d: observed %02h expected %02h", tag, i, obs_q[i], exp_q[i]);
            check($sformatf("%s_char%0d", tag, i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string p;
        int    len;

        rst = 1'b1;
        bus_if.dot = 1'b0; bus_if.dash = 1'b0; bus_if.lg = 1'b0; bus_if.wg = 1'b0;
        bus_if.char_ready = 1'b0;
        m_any = 1'b0; m_last_space = 1'b0;
        wait_ticks(2);
        check("reset_valid", {31'd0, bus_if.char_valid}, 32'd0);
        check("reset_data", {24'd0, bus_if.char_data}, 32'd0);
        check("reset_overflow", {31'd0, bus_if.overflow}, 32'd0);
        rst = 1'b0;
        wait_ticks(2);

        // 'A' and its two-cycle latency from the letter gap.
        send_sym(1'b0);
        send_sym(1'b1);
        send_lg();
        check("A_valid_lg+1", {31'd0, bus_if.char_valid}, 32'd0);
        tick();
        check("A_valid_lg+1b", {31'd0, bus_if.char_valid}, 32'd0);
        tick();
        check("A_valid_lg+2", {31'd0, bus_if.char_valid}, 32'd1);
        check("A_data", {24'd0, bus_if.char_data}, 32'h41);
        m_letter(".-");
        drain();
        compare("A");

        // 'B' then word gap, second word gap adds nothing.
        send_pat("-...");
        send_wg();
        wait_ticks(4);
        send_wg();
        wait_ticks(4);
        m_letter("-..."); m_gap(); m_gap();
        drain();
        compare("B_space");

        // Six dots give '?', simultaneous dot+dash is ignored.
        send_pat("......");
        send_lg();
        wait_ticks(4);
        m_letter("......");
        bus_if.dot = 1'b1; bus_if.dash = 1'b1;
        tick();
        bus_if.dot = 1'b0; bus_if.dash = 1'b0;
        send_lg();
        wait_ticks(4);
        drain();
        compare("bad_and_both");

        // A dot arriving while the previous letter is in LOOKUP starts the next letter.
        send_sym(1'b1);
        send_lg();
        send_sym(1'b0);
        wait_ticks(4);
        send_lg();
        wait_ticks(4);
        m_letter("-"); m_letter(".");
        drain();
        compare("sym_in_lookup");

        // Overflow: five 'E' with no consumer keep four.
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("ovf_before_5th", {31'd0, bus_if.overflow}, 32'd0);
            send_sym(1'b0);
            send_lg();
            wait_ticks(3);
        end
        check("ovf_set", {31'd0, bus_if.overflow}, 32'd1);
        for (int i = 0; i < 4; i++) m_write("E");
        drain();
        compare("overflow");

        // Reset mid-pattern with two characters queued.
        send_pat(".");  send_lg(); wait_ticks(3);
        send_pat("-");  send_lg(); wait_ticks(3);
        send_sym(1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", {31'd0, bus_if.char_valid}, 32'd0);
        check("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete(); m_any = 1'b0; m_last_space = 1'b0;
        tick();
        send_sym(1'b0);
        send_lg();
        wait_ticks(4);
        m_letter(".");
        drain();
        compare("after_rst");

        // Word gap right after reset-like state: a space is only written after a character.
        send_wg();
        wait_ticks(4);
        m_gap();
        drain();
        compare("space_after_letter");

        // Full FIFO with pop in the same cycle as the write: no drop.
        for (int i = 0; i < 4; i++) begin
            send_sym(1'b0);
            send_lg();
            wait_ticks(3);
            m_write("E");
        end
        check("full_valid", {31'd0, bus_if.char_valid}, 32'd1);
        send_sym(1'b1);
        send_lg();
        tick();
        obs_q.push_back(bus_if.char_data);
        bus_if.char_ready = 1'b1;
        tick();
        bus_if.char_ready = 1'b0;
        m_write("T");
        check("full_pop_no_ovf", {31'd0, bus_if.overflow}, 32'd0);
        drain();
        compare("full_pop");

        // Randomized letters and gaps against the table model.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                p = MORSE[$urandom_range(0, 35)];
            end else begin
                p = "";
                len = $urandom_range(1, 6);
                for (int j = 0; j < len; j++) p = {p, ($urandom_range(0, 1) != 0) ? "-" : "."};
            end
            send_pat(p);
            if ($urandom_range(0, 3) == 0) begin
                send_wg(); m_letter(p); m_gap();
            end else begin
                send_lg(); m_letter(p);
            end
            wait_ticks(5);
            drain();
            if ($urandom_range(0, 4) == 0) begin
                send_wg(); m_gap();
                wait_ticks(4);
                drain();
            end
        end
        compare("rand");

        // Idle timeout on a pending dash.
        send_sym(1'b1);
        wait_ticks(20);
`ifdef MORSE_TIMEOUT_EN
        m_letter("-");
        check("timeout_valid", {31'd0, bus_if.char_valid}, 32'd1);
`else
        check("timeout_valid", {31'd0, bus_if.char_valid}, 32'd0);
`endif
        drain();
        compare("timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/morse_letter_assembler.md
MORSE_LETTER_ASSEMBLER -- requirements
Module: morse_letter_assembler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output character FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 35_000_000, idle cycles before auto-flush (7 units at 100 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 dot  input  1  single-cycle pulse: dot symbol decoded.
REQ-006 dash  input  1  single-cycle pulse: dash symbol decoded.
REQ-007 lg  input  1  single-cycle pulse: letter gap detected.
REQ-008 wg  input  1  single-cycle pulse: word gap detected.
REQ-009 char_data  output  8  ASCII character at FIFO head.
REQ-010 char_valid  output  1  FIFO non-empty; char_data valid.
REQ-011 char_ready  input  1  consumer accepts; pop when char_valid && char_ready.
REQ-012 overflow  output  1  sticky: a character was dropped because FIFO full.

Function
REQ-013 Pattern register: 5-bit sym plus 3-bit cnt; dot writes 0, dash writes 1 at bit position cnt, then cnt increments.
REQ-014 dot and dash asserted in the same cycle SHALL be ignored (no pattern change).
REQ-015 A 6th symbol SHALL set internal bad flag; cnt saturates at 5; sym unchanged.
REQ-016 FSM states COLLECT, LOOKUP, PUSH_CHAR, PUSH_SPACE; reset state COLLECT.
REQ-017 COLLECT + lg with cnt>0 -> LOOKUP; lg with cnt==0 SHALL be ignored.
REQ-018 LOOKUP SHALL register the ASCII code (A-Z uppercase, 0-9; any other pattern or bad set -> 0x3F '?') and go to PUSH_CHAR.
REQ-019 PUSH_CHAR SHALL write the code to the FIFO, clear sym/cnt/bad, return to COLLECT (or PUSH_SPACE if a word gap is pending).
REQ-020 Latency: lg in cycle N -> char_valid high in cycle N+2 when FIFO was empty.
REQ-021 COLLECT + wg: with cnt>0, SHALL run LOOKUP/PUSH_CHAR then PUSH_SPACE (letter at N+2, 0x20 at N+3); with cnt==0, go directly to PUSH_SPACE.
REQ-022 PUSH_SPACE SHALL write 0x20 only if the last written character was not 0x20 and at least one character was written since reset; else write nothing.
REQ-023 dot/dash arriving in LOOKUP/PUSH_CHAR/PUSH_SPACE SHALL be captured into the freshly cleared pattern, not lost; lg/wg arriving there SHALL be ignored.
REQ-024 Write when FIFO full SHALL drop the character and set overflow; simultaneous pop and write on full SHALL succeed without overflow.
REQ-025 char_data/char_valid SHALL be driven from registered FIFO state only; pop with char_ready while char_valid low SHALL do nothing.

Reset
REQ-026 On rst: FIFO empty, char_valid=0, char_data=0x00, overflow=0, sym=0, cnt=0, bad=0, space-suppress state = "nothing written", FSM=COLLECT.
REQ-027 rst mid-operation SHALL discard pending pattern and all FIFO contents immediately.

Configuration
REQ-028 Macro MORSE_TIMEOUT_EN defined: idle counter counts cycles in COLLECT with cnt>0 and no dot/dash/lg/wg; reaching TIMEOUT_CYCLES SHALL act as lg and clear the counter.
REQ-029 Macro MORSE_TIMEOUT_EN undefined: no idle counter; letters flushed only by lg/wg; TIMEOUT_CYCLES unused.

Structure
REQ-030 Shared package morse_pkg SHALL hold FSM state typedef, ASCII constants (0x20, 0x3F) and symbol encoding constants.
REQ-031 Pattern-to-ASCII table SHALL be sub-module morse_ascii_lut (combinational, inputs sym/cnt/bad, output 8-bit).

Verification
REQ-032 dot,dash,lg -> char_data 0x41 'A', char_valid at lg+2 cycles.
REQ-033 dash,dot,dot,dot,wg then wg -> FIFO holds 0x42 'B', 0x20; second wg adds nothing.
REQ-034 six dots then lg -> 0x3F; dot+dash same cycle then lg -> nothing written.
REQ-035 char_ready=0, send 5 letters 'E' (dot,lg) -> 4 stored, overflow=1; drain yields four 0x45.
REQ-036 rst asserted mid-pattern with 2 chars queued -> char_valid=0 at once, overflow=0, next dot,lg yields only 'E'.
REQ-037 MORSE_TIMEOUT_EN, TIMEOUT_CYCLES=10: dash then 10 idle cycles -> 0x54 'T' without lg; undefined -> nothing written.
